// File: rtl/enemy_pkg.sv
// Shared defaults and FSM state type for the enemy grid status block.
package enemy_pkg;
  localparam int ROWS_DEF    = 10;
  localparam int COLS_DEF    = 6;
  localparam int HP_W_DEF    = 2;
  localparam int INIT_HP_DEF = 1;

  typedef enum logic {
    IDLE   = 1'b0,
    RELOAD = 1'b1
  } state_t;
endpackage

// File: rtl/enemy_hp_row.sv
// One row of enemy hit-point counters: bulk load, single-column decrement, alive flags.
module enemy_hp_row #(
  parameter int COLS    = 6,
  parameter int HP_W    = 2,
  parameter int INIT_HP = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           load,
  input  logic                           dec,
  input  logic [$clog2(COLS)-1:0]        dec_col,
  output logic [COLS-1:0][HP_W-1:0]      hp,
  output logic [COLS-1:0]                alive
);
  localparam int CW = $clog2(COLS);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < COLS; c++) hp[c] <= HP_W'(INIT_HP);
    end else begin
      for (int c = 0; c < COLS; c++) begin
        if (load)
          hp[c] <= HP_W'(INIT_HP);
        // Saturate at zero: a dead counter is never decremented.
        else if (dec && dec_col == CW'(c) && hp[c] != '0)
          hp[c] <= hp[c] - HP_W'(1);
      end
    end
  end

  always_comb begin
    alive = '0;
    for (int c = 0; c < COLS; c++) alive[c] = (hp[c] != '0);
  end
endmodule

// File: rtl/enemy_grid_status.sv
// Enemy grid tracker: per-enemy HP, kill strobes, live count, and a row-by-row wave respawn.
// Handshake: a hit transfers on a cycle where hit_valid && hit_ready; hit_ready is low in RELOAD and whenever wave_start is high.
module enemy_grid_status
  import enemy_pkg::*;
#(
  parameter int ROWS    = ROWS_DEF,
  parameter int COLS    = COLS_DEF,
  parameter int HP_W    = HP_W_DEF,
  parameter int INIT_HP = INIT_HP_DEF
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               wave_start,
  input  logic                               hit_valid,
  input  logic [$clog2(ROWS)-1:0]            hit_row,
  input  logic [$clog2(COLS)-1:0]            hit_col,
  output logic                               hit_ready,
  output logic [ROWS-1:0][COLS-1:0]          alive,
  output logic [$clog2(ROWS*COLS+1)-1:0]     alive_count,
  output logic                               all_dead,
  output logic                               kill_pulse,
  output logic [$clog2(ROWS)-1:0]            kill_row,
  output logic [$clog2(COLS)-1:0]            kill_col,
  output logic                               wave_done,
  output logic                               state_dbg
);
  localparam int RW    = $clog2(ROWS);
  localparam int CW    = $clog2(COLS);
  localparam int CNT_W = $clog2(ROWS*COLS+1);
  localparam logic [CNT_W-1:0] TOTAL    = CNT_W'(ROWS*COLS);
  localparam logic [RW-1:0]    LAST_ROW = RW'(ROWS-1);

  state_t state, state_next;
  logic [RW-1:0] row_cnt;
  logic [ROWS-1:0][COLS-1:0][HP_W-1:0] hp;
  logic [ROWS-1:0] row_load, row_dec;
  logic [HP_W-1:0] sel_hp;
  logic accept, kill, last_reload;

  assign hit_ready   = (state == IDLE) && !wave_start;
  assign last_reload = (state == RELOAD) && (row_cnt == LAST_ROW);
  assign all_dead    = (state == IDLE) && (alive_count == '0);
  assign state_dbg   = state;

  // sel_hp stays 0 for out-of-range indices, so those hits look like hits on a dead enemy.
  always_comb begin
    sel_hp = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (hit_row == RW'(r) && hit_col == CW'(c)) sel_hp = hp[r][c];
  end

  assign accept = hit_valid && hit_ready && (sel_hp != '0);
  assign kill   = accept && (sel_hp == HP_W'(1));

  always_comb begin
    row_load = '0;
    row_dec  = '0;
    for (int r = 0; r < ROWS; r++) begin
      row_load[r] = (state == RELOAD) && (row_cnt == RW'(r));
      row_dec[r]  = accept && (hit_row == RW'(r));
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    enemy_hp_row #(
      .COLS    (COLS),
      .HP_W    (HP_W),
      .INIT_HP (INIT_HP)
    ) u_row (
      .clk     (clk),
      .reset   (reset),
      .load    (row_load[r]),
      .dec     (row_dec[r]),
      .dec_col (hit_col),
      .hp      (hp[r]),
      .alive   (alive[r])
    );
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (wave_start) state_next = RELOAD;
      RELOAD:  if (row_cnt == LAST_ROW) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      row_cnt     <= '0;
      alive_count <= TOTAL;
      kill_pulse  <= 1'b0;
      kill_row    <= '0;
      kill_col    <= '0;
      wave_done   <= 1'b0;
    end else begin
      state      <= state_next;
      kill_pulse <= kill;
      wave_done  <= last_reload;
      if (state == RELOAD) row_cnt <= last_reload ? '0 : row_cnt + RW'(1);
      if (last_reload)
        alive_count <= TOTAL;
      else if (kill && alive_count != '0)
        alive_count <= alive_count - CNT_W'(1);
      if (kill) begin
        kill_row <= hit_row;
        kill_col <= hit_col;
      end
    end
  end
endmodule

// File: tb/tb_enemy_grid_status.sv
// Directed bench: an INIT_HP=2 grid for hits/respawn/reset-abort and an INIT_HP=1 grid for full clear.
module tb_enemy_grid_status;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // INIT_HP = 2 instance
  logic        a_reset, a_wave_start, a_hit_valid;
  logic [3:0]  a_hit_row;
  logic [2:0]  a_hit_col;
  logic        a_hit_ready, a_all_dead, a_kill_pulse, a_wave_done, a_state;
  logic [9:0][5:0] a_alive;
  logic [5:0]  a_alive_count;
  logic [3:0]  a_kill_row;
  logic [2:0]  a_kill_col;

  // INIT_HP = 1 instance
  logic        b_reset, b_wave_start, b_hit_valid;
  logic [3:0]  b_hit_row;
  logic [2:0]  b_hit_col;
  logic        b_hit_ready, b_all_dead, b_kill_pulse, b_wave_done, b_state;
  logic [9:0][5:0] b_alive;
  logic [5:0]  b_alive_count;
  logic [3:0]  b_kill_row;
  logic [2:0]  b_kill_col;

  enemy_grid_status #(.ROWS(10), .COLS(6), .HP_W(2), .INIT_HP(2)) u_dut_a (
    .clk(clk), .reset(a_reset), .wave_start(a_wave_start), .hit_valid(a_hit_valid),
    .hit_row(a_hit_row), .hit_col(a_hit_col), .hit_ready(a_hit_ready), .alive(a_alive),
    .alive_count(a_alive_count), .all_dead(a_all_dead), .kill_pulse(a_kill_pulse),
    .kill_row(a_kill_row), .kill_col(a_kill_col), .wave_done(a_wave_done), .state_dbg(a_state)
  );

  enemy_grid_status #(.ROWS(10), .COLS(6), .HP_W(2), .INIT_HP(1)) u_dut_b (
    .clk(clk), .reset(b_reset), .wave_start(b_wave_start), .hit_valid(b_hit_valid),
    .hit_row(b_hit_row), .hit_col(b_hit_col), .hit_ready(b_hit_ready), .alive(b_alive),
    .alive_count(b_alive_count), .all_dead(b_all_dead), .kill_pulse(b_kill_pulse),
    .kill_row(b_kill_row), .kill_col(b_kill_col), .wave_done(b_wave_done), .state_dbg(b_state)
  );

  localparam logic [63:0] FULL = {4'h0, {60{1'b1}}};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_hit(input logic v, input logic [3:0] r, input logic [2:0] c);
    a_hit_valid = v;
    a_hit_row   = r;
    a_hit_col   = c;
  endtask

  int wd_seen;
  logic [63:0] exp_alive;

  initial begin
    a_reset = 1'b1; a_wave_start = 1'b0; a_hit(1'b0, 4'd0, 3'd0);
    b_reset = 1'b1; b_wave_start = 1'b0; b_hit_valid = 1'b0; b_hit_row = '0; b_hit_col = '0;
    tick(); tick();
    a_reset = 1'b0; b_reset = 1'b0;
    #1;

    // Reset state
    check("rst_alive", 64'(a_alive), FULL);
    check("rst_count", 64'(a_alive_count), 64'd60);
    check("rst_all_dead", 64'(a_all_dead), 64'd0);
    check("rst_ready", 64'(a_hit_ready), 64'd1);
    check("rst_kill", {a_kill_pulse, a_kill_row, a_kill_col, a_wave_done}, 64'd0);
    check("rst_state", 64'(a_state), 64'd0);

    // Two hits on (3,4): second one kills
    a_hit(1'b1, 4'd3, 3'd4);
    tick();
    check("hit1_kp", 64'(a_kill_pulse), 64'd0);
    check("hit1_count", 64'(a_alive_count), 64'd60);
    tick();
    exp_alive = FULL & ~(64'd1 << 22);
    check("hit2_kp", 64'(a_kill_pulse), 64'd1);
    check("hit2_loc", {a_kill_row, a_kill_col}, {57'd0, 4'd3, 3'd4});
    check("hit2_alive", 64'(a_alive), exp_alive);
    check("hit2_count", 64'(a_alive_count), 64'd59);
    // Third hit on the dead enemy, then out-of-range row and column
    tick();
    check("hit3_kp", 64'(a_kill_pulse), 64'd0);
    check("hit3_count", 64'(a_alive_count), 64'd59);
    a_hit(1'b1, 4'd12, 3'd0);
    tick();
    check("row12_kp", 64'(a_kill_pulse), 64'd0);
    a_hit(1'b1, 4'd0, 3'd7);
    tick();
    check("col7_kp", 64'(a_kill_pulse), 64'd0);
    check("oor_count", 64'(a_alive_count), 64'd59);
    check("oor_alive", 64'(a_alive), exp_alive);
    check("hold_loc", {a_kill_row, a_kill_col}, {57'd0, 4'd3, 3'd4});

    // Corner cell (9,5)
    a_hit(1'b1, 4'd9, 3'd5);
    tick(); tick();
    a_hit(1'b0, 4'd0, 3'd0);
    check("corner_kp", 64'(a_kill_pulse), 64'd1);
    check("corner_loc", {a_kill_row, a_kill_col}, {57'd0, 4'd9, 3'd5});
    check("corner_count", 64'(a_alive_count), 64'd58);
    tick();
    check("corner_kp_clr", 64'(a_kill_pulse), 64'd0);

    // Wave start with a simultaneous hit on (0,0)
    a_wave_start = 1'b1;
    a_hit(1'b1, 4'd0, 3'd0);
    #1;
    check("ws_ready", 64'(a_hit_ready), 64'd0);
    tick();
    wd_seen = 0;
    for (int i = 0; i < 10; i++) begin
      check("rl_ready", 64'(a_hit_ready), 64'd0);
      check("rl_all_dead", 64'(a_all_dead), 64'd0);
      check("rl_state", 64'(a_state), 64'd1);
      if (a_wave_done) wd_seen++;
      tick();
      check("rl_kp", 64'(a_kill_pulse), 64'd0);
    end
    check("wd_last", 64'(a_wave_done), 64'd1);
    if (a_wave_done) wd_seen++;
    a_wave_start = 1'b0;
    a_hit(1'b0, 4'd0, 3'd0);
    tick();
    if (a_wave_done) wd_seen++;
    check("wd_count", 64'(wd_seen), 64'd1);
    check("wave_count", 64'(a_alive_count), 64'd60);
    check("wave_alive", 64'(a_alive), FULL);
    check("wave_ready", 64'(a_hit_ready), 64'd1);
    // (0,0) must be back at HP 2
    a_hit(1'b1, 4'd0, 3'd0);
    tick();
    check("hp00_first", 64'(a_kill_pulse), 64'd0);
    tick();
    a_hit(1'b0, 4'd0, 3'd0);
    check("hp00_second", 64'(a_kill_pulse), 64'd1);
    check("hp00_count", 64'(a_alive_count), 64'd59);

    // Reset during RELOAD cycle 4
    a_wave_start = 1'b1;
    tick();
    a_wave_start = 1'b0;
    tick(); tick(); tick(); tick();
    check("mid_state", 64'(a_state), 64'd1);
    a_reset = 1'b1;
    #1;
    check("mr_state", 64'(a_state), 64'd0);
    check("mr_count", 64'(a_alive_count), 64'd60);
    check("mr_alive", 64'(a_alive), FULL);
    tick();
    a_reset = 1'b0;
    wd_seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (a_wave_done) wd_seen++;
    end
    check("mr_no_wd", 64'(wd_seen), 64'd0);
    check("mr_ready", 64'(a_hit_ready), 64'd1);

    // INIT_HP = 1: clear the whole grid
    for (int r = 0; r < 10; r++) begin
      for (int c = 0; c < 6; c++) begin
        b_hit_valid = 1'b1;
        b_hit_row   = 4'(r);
        b_hit_col   = 3'(c);
        tick();
        check("b_kp", 64'(b_kill_pulse), 64'd1);
        check("b_loc", {b_kill_row, b_kill_col}, {57'd0, 4'(r), 3'(c)});
        check("b_count", 64'(b_alive_count), 64'(59 - (r * 6 + c)));
        check("b_all_dead", 64'(b_all_dead), (r == 9 && c == 5) ? 64'd1 : 64'd0);
      end
    end
    b_hit_row = 4'd5; b_hit_col = 3'd2;
    tick();
    b_hit_valid = 1'b0;
    check("b_dead_kp", 64'(b_kill_pulse), 64'd0);
    check("b_floor", 64'(b_alive_count), 64'd0);
    check("b_alive0", 64'(b_alive), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/enemy_grid_status.md
ENEMY_GRID_STATUS -- requirements
Module: enemy_grid_status

Interface
REQ-001 SHALL have parameter ROWS, default 10, number of enemy rows.
REQ-002 SHALL have parameter COLS, default 6, number of enemy columns.
REQ-003 SHALL have parameter HP_W, default 2, hit-point counter width per enemy.
REQ-004 SHALL have parameter INIT_HP, default 1, hit points loaded per enemy; legal range 1..2^HP_W-1.
REQ-005 SHALL have port clk  input  1  rising-edge system clock.
REQ-006 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port wave_start  input  1  single-cycle request to respawn the whole grid.
REQ-008 SHALL have port hit_valid  input  1  hit request present.
REQ-009 SHALL have port hit_row  input  RW=$clog2(ROWS)  row index of hit.
REQ-010 SHALL have port hit_col  input  CW=$clog2(COLS)  column index of hit.
REQ-011 SHALL have port hit_ready  output  1  hit accepted this cycle when high with hit_valid.
REQ-012 SHALL have port alive  output  ROWS x COLS  per-enemy alive flag, [row][col].
REQ-013 SHALL have port alive_count  output  CNT_W=$clog2(ROWS*COLS+1)  number of live enemies.
REQ-014 SHALL have port all_dead  output  1  high when alive_count==0 and not reloading.
REQ-015 SHALL have port kill_pulse  output  1  one-cycle strobe: an enemy just died.
REQ-016 SHALL have port kill_row / kill_col  output  RW / CW  indices of enemy killed, valid with kill_pulse.
REQ-017 SHALL have port wave_done  output  1  one-cycle strobe: respawn finished.

Function
REQ-018 SHALL implement states IDLE and RELOAD; all logic synchronous to clk except reset.
REQ-019 hit_ready SHALL equal (state==IDLE) && !wave_start (combinational).
REQ-020 Accepted hit (hit_valid && hit_ready) on a live, in-range enemy SHALL decrement its HP by 1, registered next edge.
REQ-021 If that HP was 1: next cycle alive bit clears, alive_count decrements by 1, kill_pulse=1 with kill_row/kill_col = hit indices.
REQ-022 Accepted hit on a dead enemy, or hit_row>=ROWS, or hit_col>=COLS, SHALL change no state and raise no kill_pulse.
REQ-023 HP SHALL never wrap below 0; alive_count SHALL never wrap below 0.
REQ-024 wave_start in IDLE SHALL move to RELOAD; any hit_valid that cycle is not accepted (wave_start wins).
REQ-025 RELOAD SHALL last exactly ROWS cycles, reloading row r (HP=INIT_HP, alive=1 for all COLS) on RELOAD cycle r, r=0..ROWS-1.
REQ-026 On the last RELOAD cycle's edge: alive_count=ROWS*COLS, state=IDLE, wave_done=1 for one cycle.
REQ-027 wave_start during RELOAD SHALL be ignored; hit_ready SHALL be 0 throughout RELOAD.
REQ-028 all_dead SHALL be 0 during RELOAD; kill_pulse SHALL be 0 in every cycle without a qualifying kill.
REQ-029 kill_row/kill_col SHALL hold last value when kill_pulse=0.

Reset
REQ-030 reset SHALL asynchronously set: every HP=INIT_HP, every alive=1, alive_count=ROWS*COLS, state=IDLE.
REQ-031 reset SHALL clear kill_pulse, wave_done, kill_row, kill_col to 0; all_dead=0.
REQ-032 reset asserted mid-RELOAD SHALL abort the sweep; post-reset grid is fully alive without wave_done.

Structure
REQ-033 Package enemy_pkg SHALL hold default ROWS/COLS/HP_W/INIT_HP constants and the state enum (IDLE, RELOAD).
REQ-034 Sub-module enemy_hp_row SHALL hold one row of COLS HP counters with load, decrement-by-column, and alive outputs; instantiated ROWS times.
REQ-035 Row reload counter SHALL be RW bits wide, reset to 0.

Verification (ROWS=10, COLS=6, HP_W=2, INIT_HP=2 unless noted)
REQ-036 Reset release -> alive all 1, alive_count=60, all_dead=0, hit_ready=1.
REQ-037 Hit (3,4) twice in consecutive cycles -> no kill after first; second -> next cycle kill_pulse=1, kill_row=3, kill_col=4, alive[3][4]=0, alive_count=59.
REQ-038 Third hit on (3,4), and hit at row 12 / col 7 -> no kill_pulse, alive_count stays 59.
REQ-039 INIT_HP=1: hit all 60 cells once -> alive_count reaches 0, all_dead=1 on cycle after final kill.
REQ-040 wave_start with simultaneous hit_valid on (0,0) -> hit_ready=0, hit dropped; hit_ready low 10 cycles, wave_done pulses once, alive_count=60, (0,0) HP=2.
REQ-041 reset asserted in RELOAD cycle 4 -> immediate full grid, state IDLE, no wave_done pulse.
